// File: rtl/byte_pair_pkg.sv
// Purpose: shared types and frame constants for the byte-pair serial receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package byte_pair_pkg;

   // Receiver FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam int BYTE_W     = 8;
   localparam int FRAME_BITS = 10;   // start + 8 data + stop

endpackage

// File: rtl/rx_sync.sv
// Purpose: two-flop synchroniser for the raw serial line, resetting to idle-high.
// Latency: 2 clk cycles from rx_serial to rx_s.
// Backpressure: none; free-running.
module rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic i_rx,
   output logic o_rx_s
);

   logic r_meta;
   logic r_sync;

   // Two-stage metastability filter; reset to 1 so a reset never looks like a start bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_rx;
         r_sync <= r_meta;
      end
   end

   assign o_rx_s = r_sync;

endmodule

// File: rtl/byte_pair_rx.sv
// Purpose: UART-style receiver (8N1, MSB first) that assembles byte pairs for the prefix-XOR decoder.
// Latency: pair_valid one clk after byte-1 stop sample (~19.5 bit times after byte-0 start + 2 sync cycles).
// Backpressure: none; pairs are strobed once, framing faults and timeouts drop the partial pair.
// Optional: define BYTE_PAIR_TIMEOUT_EN to abandon a lone byte 0 after TIMEOUT_BITS idle bit times.
module byte_pair_rx
   import byte_pair_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int TIMEOUT_BITS = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_serial,
   output logic [BYTE_W-1:0] data_0,
   output logic [BYTE_W-1:0] data_1,
   output logic              pair_valid,
   output logic              frame_error,
   output logic              busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(CLKS_PER_BIT/2 - 1);
   localparam logic [CNT_W-1:0] FULL_LD  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       BIT_LAST = 3'(FRAME_BITS - 3);

   logic              w_rx_s;
   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_bit_cnt;
   logic [BYTE_W-1:0] r_shift;
   logic [BYTE_W-1:0] r_hold_0;
   logic              r_idx;
   logic              r_brk;
   logic [BYTE_W-1:0] r_data_0;
   logic [BYTE_W-1:0] r_data_1;
   logic              r_pair_vld;
   logic              r_ferr;

`ifdef BYTE_PAIR_TIMEOUT_EN
   localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TO_W   = $clog2(TO_CYC + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);
   logic [TO_W-1:0] r_to_cnt;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_BITS > 0);
`endif

   rx_sync u_rx_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_rx   (rx_serial),
      .o_rx_s (w_rx_s)
   );

   // Receive FSM, bit timing, pair assembly and strobe generation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_hold_0   <= '0;
         r_idx      <= 1'b0;
         r_brk      <= 1'b0;
         r_data_0   <= '0;
         r_data_1   <= '0;
         r_pair_vld <= 1'b0;
         r_ferr     <= 1'b0;
`ifdef BYTE_PAIR_TIMEOUT_EN
         r_to_cnt   <= '0;
`endif
      end else begin
         r_pair_vld <= 1'b0;
         r_ferr     <= 1'b0;
         case (r_state)
            IDLE: begin
`ifdef BYTE_PAIR_TIMEOUT_EN
               // Timeout wins over a start edge on the expiry cycle; that start is picked up next cycle as byte 0
               if (r_idx && (r_to_cnt == TO_LAST)) begin
                  r_ferr   <= 1'b1;
                  r_idx    <= 1'b0;
                  r_hold_0 <= '0;
                  r_to_cnt <= '0;
               end else begin
                  if (r_idx) begin
                     r_to_cnt <= r_to_cnt + 1'b1;
                  end
                  if (!w_rx_s) begin
                     r_state <= START;
                     r_cnt   <= HALF_LD;
                  end
               end
`else
               if (!w_rx_s) begin
                  r_state <= START;
                  r_cnt   <= HALF_LD;
               end
`endif
            end
            START: begin
               if (r_cnt == '0) begin
                  if (!w_rx_s) begin
                     r_state   <= DATA;
                     r_cnt     <= FULL_LD;
                     r_bit_cnt <= '0;
                  end else begin
                     r_state <= IDLE;   // false start: glitch shorter than half a bit
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            DATA: begin
               if (r_cnt == '0) begin
                  r_shift   <= {r_shift[BYTE_W-2:0], w_rx_s};
                  r_cnt     <= FULL_LD;
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == BIT_LAST) begin
                     r_state <= STOP;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            STOP: begin
               if (r_brk) begin
                  // After a framing fault, wait for the line to return high so a break is not a start
                  if (w_rx_s) begin
                     r_brk   <= 1'b0;
                     r_state <= IDLE;
                  end
               end else if (r_cnt == '0) begin
                  if (w_rx_s) begin
                     r_state <= IDLE;
                     if (!r_idx) begin
                        r_hold_0 <= r_shift;
                        r_idx    <= 1'b1;
`ifdef BYTE_PAIR_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                     end else begin
                        r_data_0   <= r_hold_0;
                        r_data_1   <= r_shift;
                        r_pair_vld <= 1'b1;
                        r_idx      <= 1'b0;
                     end
                  end else begin
                     r_ferr   <= 1'b1;
                     r_idx    <= 1'b0;
                     r_hold_0 <= '0;
                     r_brk    <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign data_0      = r_data_0;
   assign data_1      = r_data_1;
   assign pair_valid  = r_pair_vld;
   assign frame_error = r_ferr;
   assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_byte_pair_rx.sv
// Purpose: self-checking bench for byte_pair_rx against a byte-level pairing model.
// Latency: n/a.
// Backpressure: n/a.
module tb_byte_pair_rx;

   localparam int CPB   = 16;
   localparam int TB_TO = 4;

   logic       clk;
   logic       rst_n;
   logic       rx_serial;
   logic [7:0] data_0;
   logic [7:0] data_1;
   logic       pair_valid;
   logic       frame_error;
   logic       busy;

   int n_chk = 0;
   int n_err = 0;

   // observed
   logic [15:0] got_q[$];
   int          got_ferr = 0;
   int          got_both = 0;

   // reference model state
   logic [15:0] exp_q[$];
   int          exp_ferr = 0;
   bit          m_idx = 0;
   logic [7:0]  m_hold = 8'h00;
   logic [7:0]  m_d0 = 8'h00;
   logic [7:0]  m_d1 = 8'h00;

   byte_pair_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TB_TO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_serial   (rx_serial),
      .data_0      (data_0),
      .data_1      (data_1),
      .pair_valid  (pair_valid),
      .frame_error (frame_error),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Collect strobes on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (pair_valid) got_q.push_back({data_0, data_1});
         if (frame_error) got_ferr++;
         if (pair_valid && frame_error) got_both++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      rx_serial = b;
      repeat (CPB) @(negedge clk);
   endtask

   // Model: one byte delivered with good or bad stop, followed by idle_bits of high line
   task automatic model_byte(input logic [7:0] b, input bit ok, input int idle_bits);
      if (!ok) begin
         exp_ferr++;
         m_idx = 0;
      end else if (!m_idx) begin
         m_hold = b;
         m_idx  = 1;
`ifdef BYTE_PAIR_TIMEOUT_EN
         // half a stop bit plus the idle gap is the time byte 0 waits
         if (2 * idle_bits + 1 > 2 * TB_TO) begin
            exp_ferr++;
            m_idx = 0;
         end
`endif
      end else begin
         exp_q.push_back({m_hold, b});
         m_d0  = m_hold;
         m_d1  = b;
         m_idx = 0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit ok, input int idle_bits);
      drive_bit(1'b0);
      for (int i = 7; i >= 0; i--) drive_bit(b[i]);
      drive_bit(ok);
      model_byte(b, ok, idle_bits);
      for (int i = 0; i < idle_bits; i++) drive_bit(1'b1);
   endtask

   task automatic check_sb(input string tag);
      chk({tag, "_npairs"}, got_q.size(), exp_q.size());
      while (got_q.size() > 0 && exp_q.size() > 0)
         chk({tag, "_pair"}, got_q.pop_front(), exp_q.pop_front());
      got_q.delete();
      exp_q.delete();
      chk({tag, "_ferr"}, got_ferr, exp_ferr);
      chk({tag, "_both"}, got_both, 0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_data"}, {data_0, data_1}, {m_d0, m_d1});
   endtask

   initial begin
      logic [7:0] a;
      logic [7:0] b;
      bit         bad;

      rx_serial = 1'b1;
      rst_n     = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_d0", data_0, 8'h00);
      chk("rst_d1", data_1, 8'h00);
      chk("rst_pv", pair_valid, 1'b0);
      chk("rst_fe", frame_error, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      repeat (2 * CPB) @(negedge clk);

      // basic pair
      send_byte(8'hA5, 1, 0);
      send_byte(8'h3C, 1, 2);
      check_sb("basic");

      // quarter-bit glitch: false start, no strobes
      rx_serial = 1'b0;
      repeat (CPB / 4) @(negedge clk);
      rx_serial = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      check_sb("glitch");

      // bad stop bit followed by a 3-bit break
      send_byte(8'h81, 0, 0);
      for (int i = 0; i < 3; i++) drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      check_sb("break");
      send_byte(8'hFF, 1, 0);
      send_byte(8'h00, 1, 2);
      check_sb("after_break");

      // reset during byte-1 data bit 4
      send_byte(8'h5A, 1, 0);
      a = 8'hC3;
      drive_bit(1'b0);
      for (int i = 7; i >= 5; i--) drive_bit(a[i]);
      rx_serial = a[4];
      repeat (CPB / 2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_d0", data_0, 8'h00);
      chk("mid_rst_d1", data_1, 8'h00);
      chk("mid_rst_pv", pair_valid, 1'b0);
      chk("mid_rst_fe", frame_error, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      m_idx = 0;
      m_d0  = 8'h00;
      m_d1  = 8'h00;
      rx_serial = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      check_sb("post_rst_idle");
      send_byte(8'h12, 1, 0);
      send_byte(8'h34, 1, 2);
      check_sb("post_rst");

      // three back-to-back pairs, no idle between frames
      for (int p = 0; p < 3; p++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         send_byte(a, 1, 0);
         send_byte(b, 1, 0);
      end
      drive_bit(1'b1);
      drive_bit(1'b1);
      check_sb("b2b");

      // randomized pairs, occasional framing faults and small gaps
      for (int p = 0; p < 8; p++) begin
         a   = 8'($urandom);
         b   = 8'($urandom);
         bad = ($urandom_range(0, 4) == 0);
         send_byte(a, !bad, bad ? 1 : $urandom_range(0, 2));
         send_byte(b, 1, $urandom_range(0, 2));
      end
      if (m_idx) send_byte(8'($urandom), 1, 0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      check_sb("random");

`ifdef BYTE_PAIR_TIMEOUT_EN
      // lone byte 0 times out, then a fresh pair is accepted
      send_byte(8'h55, 1, 5);
      send_byte(8'h66, 1, 0);
      send_byte(8'h77, 1, 2);
      check_sb("timeout");
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
